// File: rtl/gmii_tx_framer_pkg.sv
// Shared constants, state encoding and CRC-32 helpers for the GMII transmit framer.
package gmii_tx_framer_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          PRE_LEN       = 7;
    localparam int          FCS_LEN       = 4;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        SFD      = 3'd2,
        DATA     = 3'd3,
        PAD      = 3'd4,
        FCS      = 3'd5,
        DRAIN    = 3'd6,
        IFG      = 3'd7
    } state_t;

    // Reflected (LSB-first) update: the polynomial is bit-reversed before use.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  d);
        logic [31:0] c;
        logic [31:0] p;
        for (int i = 0; i < 32; i++) p[i] = CRC_POLY[31-i];
        c = crc ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ p) : (c >> 1);
        return c;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ethernet_crc_8.sv
// Byte-wise Ethernet CRC-32 engine with a serialized, complemented FCS output.
module ethernet_crc_8
    import gmii_tx_framer_pkg::*;
(
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_init,
    input  logic       i_calc,
    input  logic [7:0] i_data,
    input  logic       i_shift,
    output logic [7:0] o_crc_byte
);

    logic [31:0] r_crc;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_crc <= CRC_INIT;
        end else if (i_init) begin
            r_crc <= CRC_INIT;
        end else if (i_calc) begin
            r_crc <= crc32_byte(r_crc, i_data);
        end else if (i_shift) begin
            r_crc <= {8'hFF, r_crc[31:8]};
        end
    end

    assign o_crc_byte = ~r_crc[7:0];

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD insertion, padding, FCS append,
// underrun abort with drain, and inter-frame gap enforcement.
module gmii_tx_framer
    import gmii_tx_framer_pkg::*;
#(
    parameter int PAD_EN  = 1,
    parameter int MIN_LEN = 60,
    parameter int IFG_LEN = 12
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       frame_sent,
    output logic       frame_err
);

    state_t      r_state;
    state_t      w_state_nx;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nx;
    logic [15:0] w_cnt_inc;
    logic [7:0]  w_txd;
    logic        w_en;
    logic        w_er;
    logic        w_sent;
    logic        w_err;
    logic        w_rst;
    logic        w_crc_init;
    logic        w_crc_calc;
    logic        w_crc_shift;
    logic [7:0]  w_crc_data;
    logic [7:0]  w_crc_byte;

    assign w_rst     = ~resetn;
    assign w_cnt_inc = sat_inc(r_cnt);

    ethernet_crc_8 u_crc (
        .clk        (clk),
        .i_rst      (w_rst),
        .i_init     (w_crc_init),
        .i_calc     (w_crc_calc),
        .i_data     (w_crc_data),
        .i_shift    (w_crc_shift),
        .o_crc_byte (w_crc_byte)
    );

    // The state names the byte being chosen now; it reaches the wire next cycle.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_txd       = 8'h00;
        w_en        = 1'b0;
        w_er        = 1'b0;
        w_sent      = 1'b0;
        w_err       = 1'b0;
        w_crc_init  = 1'b0;
        w_crc_calc  = 1'b0;
        w_crc_shift = 1'b0;
        w_crc_data  = s_data;
        s_ready     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_crc_init = 1'b1;
                w_cnt_nx   = '0;
                if (s_valid) begin
                    w_txd      = PREAMBLE_BYTE;
                    w_en       = 1'b1;
                    w_state_nx = PREAMBLE;
                end
            end
            PREAMBLE: begin
                w_txd    = PREAMBLE_BYTE;
                w_en     = 1'b1;
                w_cnt_nx = w_cnt_inc;
                if (r_cnt == 16'(PRE_LEN - 2)) begin
                    w_cnt_nx   = '0;
                    w_state_nx = SFD;
                end
            end
            SFD: begin
                w_txd      = SFD_BYTE;
                w_en       = 1'b1;
                w_state_nx = DATA;
            end
            DATA: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    w_txd      = s_data;
                    w_en       = 1'b1;
                    w_crc_calc = 1'b1;
                    w_cnt_nx   = w_cnt_inc;
                    if (s_last) begin
                        if (PAD_EN != 0 && w_cnt_inc < 16'(MIN_LEN)) begin
                            w_state_nx = PAD;
                        end else begin
                            w_cnt_nx   = '0;
                            w_state_nx = FCS;
                        end
                    end
                end else begin
                    w_en       = 1'b1;
                    w_er       = 1'b1;
                    w_err      = 1'b1;
                    w_state_nx = DRAIN;
                end
            end
            PAD: begin
                w_en       = 1'b1;
                w_crc_calc = 1'b1;
                w_crc_data = 8'h00;
                w_cnt_nx   = w_cnt_inc;
                if (w_cnt_inc >= 16'(MIN_LEN)) begin
                    w_cnt_nx   = '0;
                    w_state_nx = FCS;
                end
            end
            FCS: begin
                w_txd       = w_crc_byte;
                w_en        = 1'b1;
                w_crc_shift = 1'b1;
                w_cnt_nx    = w_cnt_inc;
                if (r_cnt == 16'(FCS_LEN - 1)) begin
                    w_sent     = 1'b1;
                    w_cnt_nx   = '0;
                    w_state_nx = IFG;
                end
            end
            DRAIN: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    w_cnt_nx   = '0;
                    w_state_nx = IFG;
                end
            end
            IFG: begin
                w_cnt_nx = w_cnt_inc;
                if (r_cnt >= 16'(IFG_LEN - 1)) begin
                    w_cnt_nx   = '0;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            frame_sent <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            gmii_txd   <= w_txd;
            gmii_tx_en <= w_en;
            gmii_tx_er <= w_er;
            frame_sent <= w_sent;
            frame_err  <= w_err;
        end
    end

endmodule

// File: doc/gmii_tx_framer.md
GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

Interface
REQ-001 SHALL have parameter PAD_EN, default 1: pad short frames to MIN_LEN.
REQ-002 SHALL have parameter MIN_LEN, default 60: minimum payload+pad bytes before the FCS.
REQ-003 SHALL have parameter IFG_LEN, default 12: minimum idle cycles between frames.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port s_data, input, 8 bits: payload byte (destination MAC onward, no FCS).
REQ-007 SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-008 SHALL have port s_last, input, 1 bit: the current byte is the last payload byte.
REQ-009 SHALL have port s_ready, output, 1 bit: the block accepts s_data this cycle.
REQ-010 SHALL have port gmii_txd, output, 8 bits: GMII transmit data.
REQ-011 SHALL have port gmii_tx_en, output, 1 bit: GMII transmit enable.
REQ-012 SHALL have port gmii_tx_er, output, 1 bit: GMII transmit error.
REQ-013 SHALL have port frame_sent, output, 1 bit: one-cycle pulse on a good frame end.
REQ-014 SHALL have port frame_err, output, 1 bit: one-cycle pulse on an aborted frame.

Function
REQ-015 SHALL register all gmii_* outputs; a byte accepted on cycle k SHALL appear on gmii_txd at cycle k+1.
REQ-016 SHALL use states IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DRAIN, IFG.
REQ-017 IDLE SHALL move to PREAMBLE when s_valid=1, without consuming the byte.
- The first 0x55 SHALL appear on the next cycle.
REQ-018 SHALL emit, with gmii_tx_en=1: 7 bytes of 0x55, then 0xD5, then payload, then pad, then 4 FCS bytes.
REQ-019 s_ready SHALL be high exactly in cycles whose next output byte is a payload byte, plus all DRAIN cycles.
REQ-020 SHALL transfer a byte when s_valid and s_ready are both 1.
- s_last on a transfer SHALL end DATA.
REQ-021 SHALL count payload+pad bytes with a 16-bit saturating counter.
REQ-022 After s_last, SHALL go to PAD if PAD_EN=1 and count<MIN_LEN, otherwise to FCS.
- PAD SHALL emit 0x00 until count=MIN_LEN.
REQ-023 CRC SHALL be CRC-32: polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF.
- CRC SHALL cover payload and pad only.
- FCS SHALL be the complemented CRC, least-significant byte first.
REQ-024 Underrun SHALL be s_valid=0 while in DATA with s_ready=1.
- Next cycle: gmii_tx_en=1, gmii_tx_er=1, gmii_txd=0x00, frame_err pulse.
- Then SHALL enter DRAIN with gmii_tx_en=0.
REQ-025 DRAIN SHALL discard accepted bytes until a transfer with s_last=1, then enter IFG.
REQ-026 frame_sent SHALL pulse in the cycle the last FCS byte is driven.
REQ-027 IFG SHALL hold gmii_tx_en=0 and s_ready=0 for exactly IFG_LEN cycles, then return to IDLE.
- With s_valid held high, back-to-back frames SHALL show exactly IFG_LEN idle cycles between them.
REQ-028 gmii_tx_er SHALL be 0 in every cycle except the underrun cycle.
REQ-029 SHALL accept s_last on the first payload byte (1-byte frame).

Reset
REQ-030 resetn=0 SHALL immediately force, independent of clk:
- state=IDLE, counters=0, CRC=0xFFFFFFFF;
- gmii_txd=0, gmii_tx_en=0, gmii_tx_er=0;
- s_ready=0, frame_sent=0, frame_err=0.
REQ-031 Reset mid-frame SHALL truncate the frame with no error signalling.
- The first frame after reset release SHALL be complete and correct.

Structure
REQ-032 Shared package SHALL hold: preamble byte 0x55, SFD 0xD5, CRC polynomial/init, state encodings.
REQ-033 SHALL instantiate the existing ethernet_crc_8 byte-wise CRC engine as its one sub-module.
- Its active-high reset SHALL be driven by ~resetn.
- FCS bytes SHALL be taken from its serialized crc output.

Verification
REQ-034 PAD_EN=0, payload 31..39 ("123456789") -> 55x7, D5, 31..39, 26 39 F4 CB; 21 tx_en cycles; frame_sent once.
REQ-035 PAD_EN=1, single byte AA -> AA, 59x00, FCS matching reference model; 72 tx_en cycles.
REQ-036 Two 64-byte frames with s_valid held high -> exactly 12 idle cycles between tx_en falling and rising.
REQ-037 s_valid dropped after 10 payload bytes -> one cycle tx_en=1, tx_er=1, txd=00; frame_err pulse; remaining bytes drained; then IFG.
REQ-038 resetn low during FCS byte 2 -> all outputs 0 before the next clk edge; the following frame passes the receive-side CRC checker with crc_ok=1.
